// File: rtl/uart_pkg.sv
// Shared ASCII constants, message lengths and sender state encoding.
package uart_pkg;

  localparam logic [7:0] AsciiZero     = 8'h30;
  localparam logic [7:0] AsciiColon    = 8'h3A;
  localparam logic [7:0] AsciiQuestion = 8'h3F;
  localparam logic [7:0] AsciiCr       = 8'h0D;
  localparam logic [7:0] AsciiLf       = 8'h0A;

  localparam int MsgLenCrLf   = 10;
  localparam int MsgLenNoCrLf = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_e;

endpackage

// File: rtl/bcd_digit_to_ascii.sv
// One BCD nibble to its ASCII character; combinational, no flow control.
// Non-decimal nibbles (10..15) render as '?' so corrupt time is visible on the wire.
module bcd_digit_to_ascii
  import uart_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] ascii
);

  assign ascii = (digit < 4'd10) ? (AsciiZero + {4'h0, digit}) : AsciiQuestion;

endmodule

// File: rtl/uart_time_sender.sv
// Sends "HH:MM:SS[\r\n]" byte by byte to a UART transmitter; first tx_start 1 cycle after send.
// Paced by tx_done rising edges; send ignored while busy; aborts with error after TimeoutCycles.
module uart_time_sender
  import uart_pkg::*;
#(
  parameter int IncludeCrLf   = 1,
  parameter int TimeoutCycles = 2_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] hours,
  input  logic [7:0] minutes,
  input  logic [7:0] seconds,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  output logic       busy,
  output logic       sent,
  output logic       error
);

  localparam int MsgLen = (IncludeCrLf != 0) ? MsgLenCrLf : MsgLenNoCrLf;
  localparam logic [3:0] LastIdx = 4'(MsgLen - 1);
  localparam int CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCycles - 1);

  tx_state_e       state, state_next;
  logic [3:0]      byte_idx;
  logic [CntW-1:0] wait_cnt;
  logic [7:0]      hours_q, minutes_q, seconds_q;
  logic            tx_done_q;
  logic            sent_q, error_q;

  logic            accept, done_edge, last_byte, timed_out;
  logic            is_digit;
  logic [3:0]      nibble;
  logic [7:0]      digit_ascii, fixed_char, cur_byte;

  // The sent cycle is already IDLE, but a request there would look like a
  // duplicate of the message just finished, so it is refused.
  assign accept    = send & ~sent_q;
  assign done_edge = tx_done & ~tx_done_q;
  assign last_byte = (byte_idx == LastIdx);
  // wait_cnt counts cycles since tx_start, so this fires TimeoutCycles after it.
  assign timed_out = (wait_cnt == TimeoutLast);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (accept) state_next = START;
      START:     state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (done_edge)      state_next = last_byte ? IDLE : START;
        else if (timed_out) state_next = IDLE;
      end
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    is_digit   = 1'b0;
    nibble     = 4'h0;
    fixed_char = 8'h00;
    case (byte_idx)
      4'd0: begin is_digit = 1'b1; nibble = hours_q[7:4];   end
      4'd1: begin is_digit = 1'b1; nibble = hours_q[3:0];   end
      4'd2: fixed_char = AsciiColon;
      4'd3: begin is_digit = 1'b1; nibble = minutes_q[7:4]; end
      4'd4: begin is_digit = 1'b1; nibble = minutes_q[3:0]; end
      4'd5: fixed_char = AsciiColon;
      4'd6: begin is_digit = 1'b1; nibble = seconds_q[7:4]; end
      4'd7: begin is_digit = 1'b1; nibble = seconds_q[3:0]; end
      4'd8: fixed_char = AsciiCr;
      4'd9: fixed_char = AsciiLf;
      default: fixed_char = 8'h00;
    endcase
  end

  bcd_digit_to_ascii u_digit (
    .digit (nibble),
    .ascii (digit_ascii)
  );

  assign cur_byte = is_digit ? digit_ascii : fixed_char;
  assign busy     = (state != IDLE);
  assign tx_start = (state == START);
  assign tx_data  = busy ? cur_byte : 8'h00;
  assign sent     = sent_q;
  assign error    = error_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      byte_idx  <= 4'd0;
      wait_cnt  <= '0;
      hours_q   <= 8'h00;
      minutes_q <= 8'h00;
      seconds_q <= 8'h00;
      tx_done_q <= 1'b1;
      sent_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state     <= state_next;
      tx_done_q <= tx_done;
      sent_q    <= (state == WAIT_DONE) && done_edge && last_byte;
      error_q   <= (state == WAIT_DONE) && !done_edge && timed_out;

      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (accept) begin
            byte_idx  <= 4'd0;
            hours_q   <= hours;
            minutes_q <= minutes;
            seconds_q <= seconds;
          end
        end
        START:     wait_cnt <= CntW'(1);
        WAIT_DONE: begin
          wait_cnt <= wait_cnt + CntW'(1);
          if (done_edge) begin
            byte_idx <= last_byte ? 4'd0 : (byte_idx + 4'd1);
          end else if (timed_out) begin
            byte_idx <= 4'd0;
          end
        end
        default:   wait_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_time_sender.sv
// Randomized and directed checks of uart_time_sender against a message-level reference model.
module tb_uart_time_sender;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] hours, minutes, seconds;
  logic       send[2];
  logic       tx_done[2];
  logic       tx_start[2];
  logic [7:0] tx_data[2];
  logic       busy[2];
  logic       sent[2];
  logic       error[2];

  always #5 clock = ~clock;

  uart_time_sender #(.IncludeCrLf(1), .TimeoutCycles(100)) u_dut0 (
    .clock(clock), .reset(reset), .send(send[0]),
    .hours(hours), .minutes(minutes), .seconds(seconds),
    .tx_start(tx_start[0]), .tx_data(tx_data[0]), .tx_done(tx_done[0]),
    .busy(busy[0]), .sent(sent[0]), .error(error[0])
  );

  uart_time_sender #(.IncludeCrLf(0), .TimeoutCycles(100)) u_dut1 (
    .clock(clock), .reset(reset), .send(send[1]),
    .hours(hours), .minutes(minutes), .seconds(seconds),
    .tx_start(tx_start[1]), .tx_data(tx_data[1]), .tx_done(tx_done[1]),
    .busy(busy[1]), .sent(sent[1]), .error(error[1])
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference message: pure arithmetic on the time fields.
  function automatic logic [7:0] asc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : 8'h3F;
  endfunction

  function automatic logic [7:0] exp_byte(input int k, input logic [7:0] h, m, s);
    logic [7:0] msg[10];
    msg = '{asc(h[7:4]), asc(h[3:0]), 8'h3A, asc(m[7:4]), asc(m[3:0]), 8'h3A,
            asc(s[7:4]), asc(s[3:0]), 8'h0D, 8'h0A};
    return msg[k];
  endfunction

  function automatic int msg_len(input int i);
    return (i == 0) ? 10 : 8;
  endfunction

  // Transmitter model and output monitor.
  int         cyc = 0;
  logic [7:0] cap[2][512];
  int         start_cyc[2][512];
  int         n_cap[2]  = '{0, 0};
  int         n_sent[2] = '{0, 0};
  int         n_err[2]  = '{0, 0};
  int         err_cyc[2] = '{0, 0};
  int         dly_cnt[2] = '{0, 0};
  int         delay[2]  = '{20, 20};
  bit         hang[2]   = '{1'b0, 1'b0};

  always @(posedge clock) cyc = cyc + 1;

  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        dly_cnt[i] = 0;
        tx_done[i] = 1'b1;
      end else begin
        if (tx_start[i]) begin
          cap[i][n_cap[i] % 512]       = tx_data[i];
          start_cyc[i][n_cap[i] % 512] = cyc;
          n_cap[i]++;
          tx_done[i] = 1'b0;
          dly_cnt[i] = delay[i];
        end else if (dly_cnt[i] > 0) begin
          dly_cnt[i]--;
          if (dly_cnt[i] == 0 && !hang[i]) tx_done[i] = 1'b1;
        end
        if (sent[i]) n_sent[i]++;
        if (error[i]) begin
          n_err[i]++;
          err_cyc[i] = cyc;
        end
      end
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic run_msg(input int i, input logic [7:0] h, m, s, input int dly, input bit disturb);
    int  base_c, base_s, base_e, len;
    bit  done, poked;
    len    = msg_len(i);
    hours  = h; minutes = m; seconds = s;
    delay[i] = dly;
    hang[i]  = 1'b0;
    base_c = n_cap[i]; base_s = n_sent[i]; base_e = n_err[i];
    send[i] = 1'b1;
    step();
    send[i] = 1'b0;
    check_eq("lat_busy", busy[i], 1'b1);
    check_eq("lat_tx_start", tx_start[i], 1'b1);
    check_eq("lat_tx_data", tx_data[i], exp_byte(0, h, m, s));
    done  = 1'b0;
    poked = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      step();
      send[i] = 1'b0;
      if (disturb && !poked && (n_cap[i] - base_c) == 3) begin
        hours = 8'h00; minutes = 8'h00; seconds = 8'h00;
        send[i] = 1'b1;
        poked = 1'b1;
      end
      done = (n_sent[i] != base_s) || (n_err[i] != base_e);
    end
    send[i] = 1'b0;
    check_eq("msg_finished", done, 1'b1);
    check_eq("byte_count", n_cap[i] - base_c, len);
    for (int k = 0; k < len; k++)
      check_eq($sformatf("byte%0d", k), cap[i][(base_c + k) % 512], exp_byte(k, h, m, s));
    check_eq("sent_pulses", n_sent[i] - base_s, 1);
    check_eq("err_pulses", n_err[i] - base_e, 0);
    check_eq("sent_cycle_busy", busy[i], 1'b0);
    step();
    check_eq("sent_one_cycle", sent[i], 1'b0);
    repeat (5) step();
    check_eq("no_extra_start", n_cap[i] - base_c, len);
  endtask

  task automatic run_timeout();
    int base_c, base_s, base_e;
    bit done;
    hang[0] = 1'b1;
    base_c = n_cap[0]; base_s = n_sent[0]; base_e = n_err[0];
    send[0] = 1'b1;
    step();
    send[0] = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      step();
      done = (n_err[0] != base_e);
    end
    check_eq("to_error_seen", done, 1'b1);
    check_eq("to_error_delay", err_cyc[0] - start_cyc[0][base_c % 512], 100);
    check_eq("to_busy", busy[0], 1'b0);
    repeat (30) step();
    check_eq("to_starts", n_cap[0] - base_c, 1);
    check_eq("to_no_sent", n_sent[0] - base_s, 0);
    check_eq("to_err_once", n_err[0] - base_e, 1);
    hang[0] = 1'b0;
  endtask

  task automatic run_reset_abort();
    int  base_c, base_s;
    bit  reached;
    hours = 8'h12; minutes = 8'h34; seconds = 8'h56;
    delay[0] = 20;
    base_c = n_cap[0]; base_s = n_sent[0];
    send[0] = 1'b1;
    step();
    send[0] = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 500 && !reached; c++) begin
      step();
      reached = (n_cap[0] - base_c) == 4;
    end
    check_eq("rst_reached_byte4", reached, 1'b1);
    repeat (3) step();
    reset = 1'b0;
    #1;
    check_eq("rst_tx_start", tx_start[0], 1'b0);
    check_eq("rst_tx_data", tx_data[0], 8'h00);
    check_eq("rst_busy", busy[0], 1'b0);
    check_eq("rst_sent", sent[0], 1'b0);
    check_eq("rst_error", error[0], 1'b0);
    repeat (2) step();
    reset = 1'b1;
    repeat (40) step();
    check_eq("rst_no_resume", n_cap[0] - base_c, 4);
    check_eq("rst_no_sent", n_sent[0] - base_s, 0);
    run_msg(0, 8'h07, 8'h45, 8'h19, 9, 1'b0);
  endtask

  task automatic run_level_send();
    int  base_c, base_s;
    bit  done;
    hours = 8'h09; minutes = 8'h08; seconds = 8'h07;
    delay[1] = 4;
    base_c = n_cap[1]; base_s = n_sent[1];
    send[1] = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 1000 && !done; c++) begin
      step();
      done = (n_sent[1] - base_s) == 2;
    end
    send[1] = 1'b0;
    check_eq("lvl_two_msgs", done, 1'b1);
    repeat (20) step();
    check_eq("lvl_byte_count", n_cap[1] - base_c, 16);
    for (int k = 0; k < 16; k++)
      check_eq($sformatf("lvl_byte%0d", k), cap[1][(base_c + k) % 512],
               exp_byte(k % 8, 8'h09, 8'h08, 8'h07));
    check_eq("lvl_busy_end", busy[1], 1'b0);
  endtask

  initial begin
    send[0] = 1'b0; send[1] = 1'b0;
    hours = 8'h00; minutes = 8'h00; seconds = 8'h00;
    reset = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 2; i++) begin
      check_eq("reset_tx_start", tx_start[i], 1'b0);
      check_eq("reset_tx_data", tx_data[i], 8'h00);
      check_eq("reset_busy", busy[i], 1'b0);
      check_eq("reset_sent", sent[i], 1'b0);
      check_eq("reset_error", error[i], 1'b0);
    end
    reset = 1'b1;
    repeat (2) step();

    run_msg(0, 8'h12, 8'h34, 8'h56, 20, 1'b0);
    run_msg(1, 8'h23, 8'h59, 8'h59, 20, 1'b0);
    run_msg(0, 8'h12, 8'h34, 8'h56, 20, 1'b1);
    run_msg(0, 8'hA5, 8'h00, 8'h00, 7, 1'b0);
    run_timeout();
    run_msg(0, 8'h01, 8'h02, 8'h03, 5, 1'b0);
    run_reset_abort();
    run_level_send();

    for (int n = 0; n < 16; n++) begin
      int         i;
      logic [7:0] h, m, s;
      i = $urandom_range(0, 1);
      h = 8'($urandom);
      m = 8'($urandom);
      s = 8'($urandom);
      run_msg(i, h, m, s, $urandom_range(1, 25), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
